// File: rtl/troop_digit_overlay_if.sv
// Board RAM / BCD converter link for the troop digit overlay.
// master drives cell_addr; slave returns that cell's digits.
interface troop_digit_overlay_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] cell_addr;
  logic              digits_valid;
  logic [3:0]        hundreds;
  logic [3:0]        tens;
  logic [3:0]        ones;

  modport master (
    output cell_addr,
    input  digits_valid, hundreds, tens, ones
  );

  modport slave (
    input  cell_addr,
    output digits_valid, hundreds, tens, ones
  );
endinterface

// File: rtl/troop_digit_overlay.sv
// 3-stage VGA overlay drawing each cell's troop count as 4x7 glyphs (x2).
// Define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module troop_digit_overlay #(
  parameter logic [11:0] ORIGIN_X  = 12'd64,
  parameter logic [11:0] ORIGIN_Y  = 12'd32,
  parameter int          LOG2_CELL = 5,
  parameter int          COLS      = 16,
  parameter int          ROWS      = 16,
  parameter int          ADDR_W    = 8,
  parameter logic        SYNC_IDLE = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] hdata,
  input  logic [11:0] vdata,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  troop_digit_overlay_if.master ram,
  output logic        pixel_on,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int PW = LOG2_CELL;

  logic [11:0]       dx, dy, col, row;
  logic [23:0]       lin;
  logic              inside_c;
  logic [ADDR_W-1:0] addr_c;

  logic [ADDR_W-1:0] addr1;
  logic [PW-1:0]     px1, py1;
  logic              in1, de1, hs1, vs1;

  logic [PW-1:0]     px2, py2;
  logic              in2, de2, hs2, vs2, dv2;
  logic [3:0]        h2, t2, o2;

  logic [PW-1:0]     xo, yo;
  logic [1:0]        gcol;
  logic [2:0]        grow;
  logic              in_win, blank_h, blank_t, blank, lit;
  logic              sl_h, sl_t;
  logic [3:0]        dig, rbits;
  logic [27:0]       glyph, sh;
  logic              pix_c;

  function automatic logic [27:0] font(input logic [3:0] d);
    unique case (d)
      4'd0:    font = 28'h6999996;
      4'd1:    font = 28'h2622227;
      4'd2:    font = 28'h691248F;
      4'd3:    font = 28'hE11611E;
      4'd4:    font = 28'h999F111;
      4'd5:    font = 28'hF8E1196;
      4'd6:    font = 28'h688E996;
      4'd7:    font = 28'hF124444;
      4'd8:    font = 28'h6996996;
      4'd9:    font = 28'h6997116;
      default: font = 28'h0;
    endcase
  endfunction

  // Map the pixel to a board cell and its in-cell offset.
  always_comb begin
    dx       = hdata - ORIGIN_X;
    dy       = vdata - ORIGIN_Y;
    col      = dx >> LOG2_CELL;
    row      = dy >> LOG2_CELL;
    inside_c = de_in
            && hdata >= ORIGIN_X
            && vdata >= ORIGIN_Y
            && col < 12'(COLS)
            && row < 12'(ROWS);
    lin      = 24'(row) * 24'(COLS) + 24'(col);
    addr_c   = inside_c ? lin[ADDR_W-1:0] : '0;
  end

  // Stage 1: cell address out to RAM, offsets and video controls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr1 <= '0;
      px1   <= '0;
      py1   <= '0;
      in1   <= 1'b0;
      de1   <= 1'b0;
      hs1   <= SYNC_IDLE;
      vs1   <= SYNC_IDLE;
    end else begin
      addr1 <= addr_c;
      px1   <= dx[PW-1:0];
      py1   <= dy[PW-1:0];
      in1   <= inside_c;
      de1   <= de_in;
      hs1   <= hsync_in;
      vs1   <= vsync_in;
    end
  end

  assign ram.cell_addr = addr1;

  // Stage 2: capture the returned digits alongside the shifted pixel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      px2 <= '0;
      py2 <= '0;
      in2 <= 1'b0;
      de2 <= 1'b0;
      hs2 <= SYNC_IDLE;
      vs2 <= SYNC_IDLE;
      dv2 <= 1'b0;
      h2  <= '0;
      t2  <= '0;
      o2  <= '0;
    end else begin
      px2 <= px1;
      py2 <= py1;
      in2 <= in1;
      de2 <= de1;
      hs2 <= hs1;
      vs2 <= vs1;
      dv2 <= ram.digits_valid;
      h2  <= ram.hundreds;
      t2  <= ram.tens;
      o2  <= ram.ones;
    end
  end

  // Pick slot digit and glyph bit for the current in-cell offset.
  always_comb begin
    xo     = px2 - PW'(4);
    yo     = py2 - PW'(9);
    in_win = px2 >= PW'(4) && px2 <= PW'(27)
          && py2 >= PW'(9) && py2 <= PW'(22);
    sl_h   = xo[4:3] == 2'd0;
    sl_t   = xo[4:3] == 2'd1;
    gcol   = xo[2:1];
    grow   = yo[3:1];
`ifdef LEADING_ZERO_BLANK_EN
    blank_h = h2 == 4'd0;
    blank_t = h2 == 4'd0 && t2 == 4'd0;
`else
    blank_h = 1'b0;
    blank_t = 1'b0;
`endif
    dig = o2;
    unique case (1'b1)
      sl_h:    dig = h2;
      sl_t:    dig = t2;
      default: dig = o2;
    endcase
    blank = dig > 4'd9
         || (sl_h && blank_h)
         || (sl_t && blank_t);
    glyph = font(dig);
    sh    = glyph << (4 * grow);
    rbits = sh[27:24];
    lit   = rbits[2'd3 - gcol];
    pix_c = in2 && dv2 && in_win && !blank && lit;
  end

  // Stage 3: registered pixel and delayed video controls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pixel_on  <= 1'b0;
      de_out    <= 1'b0;
      hsync_out <= SYNC_IDLE;
      vsync_out <= SYNC_IDLE;
    end else begin
      pixel_on  <= pix_c;
      de_out    <= de2;
      hsync_out <= hs2;
      vsync_out <= vs2;
    end
  end

endmodule

// File: tb/tb_troop_digit_overlay.sv
// Scoreboard bench for troop_digit_overlay.
// Board RAM model answers late in each cycle, garbage before.
module tb_troop_digit_overlay;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] hdata = '0;
  logic [11:0] vdata = '0;
  logic        de_in = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        pixel_on, de_out, hsync_out, vsync_out;

  troop_digit_overlay_if #(.ADDR_W(8)) ram ();

  troop_digit_overlay dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .hdata     (hdata),
    .vdata     (vdata),
    .de_in     (de_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .ram       (ram),
    .pixel_on  (pixel_on),
    .de_out    (de_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic pix;
    logic de;
    logic hs;
    logic vs;
  } exp_t;

  exp_t       q[$];
  logic [7:0] qa[$];
  int         n_chk = 0;
  int         n_pass = 0;
  string      phase = "init";

  logic       bv[256];
  logic [3:0] bh[256];
  logic [3:0] bt[256];
  logic [3:0] bo[256];

  string font[10][7] = '{
    '{".##.", "#..#", "#..#", "#..#", "#..#", "#..#", ".##."},
    '{"..#.", ".##.", "..#.", "..#.", "..#.", "..#.", ".###"},
    '{".##.", "#..#", "...#", "..#.", ".#..", "#...", "####"},
    '{"###.", "...#", "...#", ".##.", "...#", "...#", "###."},
    '{"#..#", "#..#", "#..#", "####", "...#", "...#", "...#"},
    '{"####", "#...", "###.", "...#", "...#", "#..#", ".##."},
    '{".##.", "#...", "#...", "###.", "#..#", "#..#", ".##."},
    '{"####", "...#", "..#.", ".#..", ".#..", ".#..", ".#.."},
    '{".##.", "#..#", "#..#", ".##.", "#..#", "#..#", ".##."},
    '{".##.", "#..#", "#..#", ".###", "...#", "...#", ".##."}
  };

  // RAM + converter model: junk early in the cycle, real data late.
  always begin
    @(posedge clock);
    #2;
    ram.digits_valid = 1'($urandom);
    ram.hundreds     = 4'($urandom);
    ram.tens         = 4'($urandom);
    ram.ones         = 4'($urandom);
    @(negedge clock);
    ram.digits_valid = bv[ram.cell_addr];
    ram.hundreds     = bh[ram.cell_addr];
    ram.tens         = bt[ram.cell_addr];
    ram.ones         = bo[ram.cell_addr];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s.%s got=%0h exp=%0h t=%0t",
                  phase, tag, got, exp, $time);
  endtask

  function automatic int cell_of(int h, int v, bit de);
    int c, r;
    if (!de || h < 64 || v < 32) return -1;
    c = (h - 64) / 32;
    r = (v - 32) / 32;
    if (c >= 16 || r >= 16) return -1;
    return r * 16 + c;
  endfunction

  function automatic bit exp_pix(int h, int v, bit de);
    int a, px, py, s, d;
    a = cell_of(h, v, de);
    if (a < 0) return 1'b0;
    if (!bv[a]) return 1'b0;
    px = (h - 64) % 32;
    py = (v - 32) % 32;
    if (px < 4 || px > 27 || py < 9 || py > 22) return 1'b0;
    s = (px - 4) / 8;
    d = (s == 0) ? int'(bh[a]) : (s == 1) ? int'(bt[a]) : int'(bo[a]);
    if (d > 9) return 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (s == 0 && bh[a] == 0) return 1'b0;
    if (s == 1 && bh[a] == 0 && bt[a] == 0) return 1'b0;
`endif
    return font[d][(py - 9) / 2][((px - 4) % 8) / 2] == "#";
  endfunction

  task automatic drive(input int h, input int v, input bit de,
                       input bit hs, input bit vs);
    exp_t e;
    int   a;
    hdata    = 12'(h);
    vdata    = 12'(v);
    de_in    = de;
    hsync_in = hs;
    vsync_in = vs;
    e.pix = exp_pix(h, v, de);
    e.de  = de;
    e.hs  = hs;
    e.vs  = vs;
    q.push_back(e);
    a = cell_of(h, v, de);
    qa.push_back(a < 0 ? 8'd0 : 8'(a));
  endtask

  task automatic step(input int h, input int v, input bit de,
                      input bit hs, input bit vs);
    exp_t       e;
    logic [7:0] a;
    @(posedge clock);
    #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      check("pix", pixel_on, e.pix);
      check("de", de_out, e.de);
      check("hs", hsync_out, e.hs);
      check("vs", vsync_out, e.vs);
    end
    if (qa.size() == 1) begin
      a = qa.pop_front();
      check("addr", ram.cell_addr, a);
    end
    drive(h, v, de, hs, vs);
  endtask

  task automatic rst_check();
    check("rst_pix", pixel_on, 1'b0);
    check("rst_de", de_out, 1'b0);
    check("rst_hs", hsync_out, 1'b1);
    check("rst_vs", vsync_out, 1'b1);
    check("rst_addr", ram.cell_addr, 8'd0);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      rst_check();
      hdata    = 12'($urandom);
      vdata    = 12'($urandom);
      de_in    = 1'($urandom);
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
    end
  endtask

  task automatic release_reset(input int h, input int v);
    exp_t r;
    @(posedge clock);
    #1;
    rst_check();
    reset_n = 1'b1;
    q.delete();
    qa.delete();
    r.pix = 1'b0;
    r.de  = 1'b0;
    r.hs  = 1'b1;
    r.vs  = 1'b1;
    q.push_back(r);
    q.push_back(r);
    drive(h, v, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic scan_cell(input int c, input int r);
    for (int y = 7; y <= 24; y++)
      for (int x = 0; x < 32; x++)
        step(64 + c * 32 + x, 32 + r * 32 + y, 1'b1,
             1'($urandom), 1'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bv[i] = 1'($urandom);
      bh[i] = 4'($urandom_range(0, 11));
      bt[i] = 4'($urandom_range(0, 11));
      bo[i] = 4'($urandom_range(0, 11));
    end
    bv[0] = 1; bh[0] = 2; bt[0] = 0; bo[0] = 5;
    bv[1] = 1; bh[1] = 0; bt[1] = 0; bo[1] = 7;
    bv[2] = 0; bh[2] = 0; bt[2] = 0; bo[2] = 7;
    bv[3] = 1; bh[3] = 1; bt[3] = 3; bo[3] = 4'hA;
    bv[4] = 1; bh[4] = 0; bt[4] = 4; bo[4] = 2;
    bv[35] = 1; bh[35] = 9; bt[35] = 8; bo[35] = 6;

    phase = "reset";
    hold_reset(4);
    release_reset(64 + 3 * 32 + 5, 32 + 2 * 32 + 10);

    phase = "addr";
    step(63, 32 + 2 * 32 + 10, 1'b1, 1'b1, 1'b0);
    step(64 + 15 * 32 + 20, 32 + 15 * 32 + 12, 1'b1, 1'b0, 1'b1);
    step(64 + 16 * 32, 40, 1'b1, 1'b1, 1'b1);
    step(70, 32 + 16 * 32, 1'b1, 1'b0, 1'b0);
    step(64 + 3 * 32 + 12, 32 + 2 * 32 + 10, 1'b0, 1'b1, 1'b0);

    phase = "g205";
    scan_cell(0, 0);
    phase = "g007";
    scan_cell(1, 0);
    phase = "novalid";
    scan_cell(2, 0);
    phase = "badbcd";
    scan_cell(3, 0);
    phase = "g042";
    scan_cell(4, 0);
    phase = "g986";
    scan_cell(3, 2);

    phase = "random";
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 700), $urandom_range(0, 600),
           ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom));

    phase = "midreset";
    for (int x = 4; x < 12; x++)
      step(64 + x, 32 + 11, 1'b1, 1'b0, 1'b0);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    rst_check();
    hold_reset(2);
    release_reset(64 + 6, 32 + 11);
    for (int x = 7; x < 28; x++)
      step(64 + x, 32 + 11, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      step(0, 0, 1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/troop_digit_overlay.md
Name: troop_digit_overlay

Overview:
- Pipelined VGA overlay stage that draws each board cell's troop count as up to three decimal glyphs.
- Consumes the hundreds/tens/ones digits from the binary-to-BCD troop converter.
- Sits between the VGA timing generator and the final colour mux.
- Per pixel: issues the cell address to board RAM, receives that cell's digits one cycle later, selects the glyph column/row, outputs a registered pixel_on alongside delayed sync/de.

Parameters:
- ORIGIN_X, 12'd64: board left edge, pixels.
- ORIGIN_Y, 12'd32: board top edge, pixels.
- LOG2_CELL, 5: cell size 2^LOG2_CELL px (32).
- COLS, 16: board columns.
- ROWS, 16: board rows.
- ADDR_W, 8: cell_addr width, >= clog2(COLS*ROWS).
- SYNC_IDLE, 1'b1: inactive level of hsync/vsync.

Ports:
- clock  in  1  system/pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- hdata  in  12  current pixel x.
- vdata  in  12  current pixel y.
- de_in  in  1  display-enable from timing generator.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- cell_addr  out  ADDR_W  row*COLS+col, to board RAM.
- digits_valid  in  1  cell shows a count (visible, nonzero owner), valid cycle after cell_addr.
- hundreds  in  4  BCD digit, valid with digits_valid.
- tens  in  4  BCD digit.
- ones  in  4  BCD digit.
- pixel_on  out  1  glyph pixel lit.
- de_out  out  1  de_in delayed 3.
- hsync_out  out  1  hsync_in delayed 3.
- vsync_out  out  1  vsync_in delayed 3.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n).
- Reset values: all pipeline registers clear; cell_addr=0, pixel_on=0, de_out=0, hsync_out=vsync_out=SYNC_IDLE. The pipeline refills in 3 cycles after release; outputs before then reflect reset contents.
- Stage 1 (edge after input cycle T):
  - dx=hdata-ORIGIN_X, dy=vdata-ORIGIN_Y (12-bit; compare before subtracting).
  - inside = de_in && hdata>=ORIGIN_X && vdata>=ORIGIN_Y && col<COLS && row<ROWS, where col=dx>>LOG2_CELL and row=dy>>LOG2_CELL.
  - Register cell_addr=row*COLS+col, or 0 when !inside.
  - Register px=dx[LOG2_CELL-1:0], py=dy[LOG2_CELL-1:0], inside, and syncs/de.
- External: RAM plus converter return digits/digits_valid during cycle T+2 for the cell_addr presented in T+1. They are sampled only at the T+2 edge, with no other assumptions.
- Stage 2 (edge T+2): latch digits and digits_valid; shift px, py, inside, syncs, de.
- Stage 3 (edge T+3, output), glyph window:
  - Three 8-px-wide slots at px 4..11 (hundreds), 12..19 (tens), 20..27 (ones); rows py 9..22.
  - Font is 4x7, scaled x2: gcol=(px-slot_base)>>1 (0..3, MSB left), grow=(py-9)>>1 (0..6).
  - Font ROM is an internal case table of 10 glyphs.
  - BCD digit >9 renders blank.
  - pixel_on = inside && digits_valid && in_window && !blank(slot) && font[digit][grow][3-gcol].
- Latency: exactly 3 cycles input→outputs, no stalls, throughput one pixel/clock.
- Cell boundaries: px/py derived per pixel, so adjacent cells never share glyphs; px 0..3 and 28..31 are never lit.
- Reset asserted mid-frame: outputs go to reset values immediately (async); no partial glyph is retained.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: hundreds slot blank when hundreds==0; tens slot blank when hundreds==0 && tens==0; ones always drawn. Count 7 shows a single glyph in the ones slot.
- Undefined: all three slots are drawn, so 7 shows "007".

Test Plan:
- Reset: hold reset_n=0 with random inputs → pixel_on=0, de_out=0, syncs=SYNC_IDLE, cell_addr=0. Release → first valid output at cycle 3.
- Addressing: hdata=64+3*32+5, vdata=32+2*32+10 → cell_addr=2*16+3=35 one cycle later. hdata=63 → inside=0, pixel_on=0.
- Latency/sync: toggle hsync_in/de_in at cycle T → hsync_out/de_out follow at T+3. Pixel_on for a lit font bit appears at T+3 while the model returns digits at T+2.
- Glyph: cell(0,0), digits 2/0/5, valid=1, scan px 4..27, py 9..22 → lit pattern matches the scaled font model for "205". py=8 or 23 → 0.
- Blanking: digits 0/0/7 → with LEADING_ZERO_BLANK_EN no pixels in px 4..19 and the "7" glyph in 20..27; without it, "007". digits_valid=0 → no pixels.
- Bad BCD: ones=4'hA → ones slot blank; other slots unaffected.
